// File: rtl/div_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_unit : iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Revision : 1.0
// ----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             sel_rem_q, sel_rem_d;
    logic [4:0]       rd_lat_q, rd_lat_d;
    logic [4:0]       rd_q, rd_d;

    logic             is_signed, want_rem, a_neg, b_neg;
    logic             div_zero, ovf, special, accept;
    logic [WIDTH-1:0] a_abs, b_abs, special_res;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Codes outside 100/110/111 behave as DIVU: unsigned, quotient selected.
    assign is_signed   = (funct3 == 3'b100) || (funct3 == 3'b110);
    assign want_rem    = funct3[2] & funct3[1];
    assign a_neg       = is_signed & dividend[WIDTH-1];
    assign b_neg       = is_signed & divisor[WIDTH-1];
    assign a_abs       = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_abs       = b_neg ? (~divisor + 1'b1) : divisor;
    assign div_zero    = (divisor == '0);
    assign ovf         = is_signed && (dividend == MIN_INT) && (divisor == '1);
    assign special     = div_zero | ovf;
    assign special_res = div_zero ? (want_rem ? dividend : '1)
                                  : (want_rem ? '0 : MIN_INT);
    assign accept      = (state_q == IDLE) && start && !flush;

    // Partial remainder is kept one bit wider so the compare never loses the MSB.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, dvs_q});
    assign q_fix  = qneg_q ? (~quo_q + 1'b1) : quo_q;
    assign r_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        rd_lat_d  = rd_lat_q;
        result_d  = result_q;
        rd_d      = rd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_lat_d  = rd_in;
                    sel_rem_d = want_rem;
                    cnt_d     = '0;
                    if (special) begin
                        result_d = special_res;
                        rd_d     = rd_in;
                        state_d  = DONE;
                    end else begin
                        quo_d   = a_abs;
                        rem_d   = '0;
                        dvs_d   = b_abs;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    rem_d = ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = sel_rem_q ? r_fix : q_fix;
                    rd_d     = rd_lat_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            rd_lat_q  <= '0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            rd_lat_q  <= rd_lat_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign stall  = (state_q == CALC) || (state_q == FIX) || accept;
    assign result = result_q;
    assign rd_out = rd_q;

endmodule
`default_nettype wire
